// File: rtl/ps2_keyboard_rx_pkg.sv
// PS/2 keyboard receiver shared definitions.
// Prefix codes, frame geometry, frame FSM state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  localparam int PS2_DATA_BITS   = 8;
  localparam int PS2_FRAME_SHIFT = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RECV  = ST_RECV,
    CHECK = ST_CHECK
  } frame_state_t;

  function automatic logic odd_parity_ok(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Receiver output bundle: bytes, frame errors, key events.
// master = receiver side (drives), slave = consumer side.
interface ps2_keyboard_rx_if #(
  parameter int ERR_W = 8
);

  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             frame_error;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       key_code;
  logic             key_extended;
  logic             key_release;
  logic             key_valid;

  modport master (
    output byte_data, byte_valid, frame_error, err_count,
    output key_code, key_extended, key_release, key_valid
  );

  modport slave (
    input byte_data, byte_valid, frame_error, err_count,
    input key_code, key_extended, key_release, key_valid
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: sync, fall detect, frame FSM, timeout.
// Ports: Clock, Resetn, ps2_clk/ps2_dat in; byte_data/byte_valid/frame_error out.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  // Compared before the increment, so the pulse lands as the
  // counter reaches TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);

  logic clk_meta, clk_sync, clk_prev;
  logic dat_meta, dat_sync;
  logic fall;

  frame_state_t state, state_n;
  logic [PS2_FRAME_SHIFT-1:0] sr, sr_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [TW-1:0] to_cnt;
  logic [7:0] data_n;
  logic valid_n, err_n;

  assign fall = clk_prev & ~clk_sync;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn)
      to_cnt <= '0;
    else if (fall || state != RECV)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      bit_cnt     <= bit_cnt_n;
      byte_data   <= data_n;
      byte_valid  <= valid_n;
      frame_error <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    data_n    = byte_data;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        // A fall with data high is line noise, not a start bit.
        if (fall && !dat_sync) begin
          state_n   = RECV;
          bit_cnt_n = '0;
        end
      end
      RECV: begin
        if (fall) begin
          sr_n      = {dat_sync, sr[PS2_FRAME_SHIFT-1:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9)
            state_n = CHECK;
        end else if (to_cnt == TO_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      CHECK: begin
        // Any fall here is ignored.
        state_n = IDLE;
        if (odd_parity_ok(sr[8:0]) && sr[9]) begin
          valid_n = 1'b1;
          data_n  = sr[PS2_DATA_BITS-1:0];
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames, error count, E0/F0 key decoder.
// Ports: Clock, Resetn, ps2_clk, ps2_dat; rx (master) output bundle.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int ERR_W          = 8
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic ps2_clk,
  input  logic ps2_dat,
  ps2_keyboard_rx_if.master rx
);

  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             frame_error;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       key_code;
  logic             key_extended;
  logic             key_release;
  logic             key_valid;
  logic             ext_flag;
  logic             rel_flag;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .frame_error (frame_error)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn)
      err_count <= '0;
    else if (frame_error && !(&err_count))
      err_count <= err_count + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      key_code     <= '0;
      key_extended <= 1'b0;
      key_release  <= 1'b0;
      key_valid    <= 1'b0;
      ext_flag     <= 1'b0;
      rel_flag     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_error) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (byte_valid) begin
        unique case (1'b1)
          (byte_data == PS2_EXT_PREFIX):   ext_flag <= 1'b1;
          (byte_data == PS2_BREAK_PREFIX): rel_flag <= 1'b1;
          default: begin
            key_valid    <= 1'b1;
            key_code     <= byte_data;
            key_extended <= ext_flag;
            key_release  <= rel_flag;
            ext_flag     <= 1'b0;
            rel_flag     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.byte_data    = byte_data;
  assign rx.byte_valid   = byte_valid;
  assign rx.frame_error  = frame_error;
  assign rx.err_count    = err_count;
  assign rx.key_code     = key_code;
  assign rx.key_extended = key_extended;
  assign rx.key_release  = key_release;
  assign rx.key_valid    = key_valid;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: keyboard model drives frames,
// a negedge monitor pops expected bytes/keys/errors from queues.
module tb_ps2_keyboard_rx;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_t;

  logic Clock   = 1'b0;
  logic Resetn  = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [7:0] byte_q[$];
  key_t       key_q[$];
  int         err_pend = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] eb;
  key_t       ek;

  ps2_keyboard_rx_if #(.ERR_W(8)) rx();

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES(32),
    .ERR_W(8)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rx      (rx)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (rx.byte_valid) begin
      total++;
      if (byte_q.size() == 0) begin
        bad++;
        $display("FAIL byte_unexpected got=%h want=none", rx.byte_data);
      end else begin
        eb = byte_q.pop_front();
        if (rx.byte_data !== eb) begin
          bad++;
          $display("FAIL byte_data got=%h want=%h", rx.byte_data, eb);
        end
      end
    end
    if (rx.key_valid) begin
      total++;
      if (key_q.size() == 0) begin
        bad++;
        $display("FAIL key_unexpected got=%h want=none", rx.key_code);
      end else begin
        ek = key_q.pop_front();
        if (rx.key_code !== ek.code || rx.key_extended !== ek.ext ||
            rx.key_release !== ek.rel) begin
          bad++;
          $display("FAIL key got=%h/e%b/r%b want=%h/e%b/r%b",
                   rx.key_code, rx.key_extended, rx.key_release,
                   ek.code, ek.ext, ek.rel);
        end
      end
    end
    if (rx.frame_error) begin
      total++;
      if (err_pend == 0) begin
        bad++;
        $display("FAIL frame_error_unexpected got=1 want=0");
      end else begin
        err_pend--;
      end
    end
  end

  task automatic bit_out(input logic b);
    @(posedge Clock); #1 ps2_dat = b;
    repeat (2) @(posedge Clock);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge Clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip,
                            input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out((~^d) ^ pflip);
    bit_out(stop);
    #1 ps2_dat = 1'b1;
    repeat (10) @(posedge Clock);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    byte_q.push_back(d);
    last_good = d;
  endtask

  task automatic expect_key(input logic [7:0] c, input logic e,
                            input logic r);
    key_t k;
    k.code = c;
    k.ext  = e;
    k.rel  = r;
    key_q.push_back(k);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (byte_q.size() != 0 || key_q.size() != 0 || err_pend != 0) begin
      bad++;
      $display("FAIL %s_drained got=b%0d/k%0d/e%0d want=0/0/0",
               name, byte_q.size(), key_q.size(), err_pend);
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if (rx.byte_data !== 8'h00 || rx.byte_valid !== 1'b0 ||
        rx.frame_error !== 1'b0 || rx.err_count !== 8'h00 ||
        rx.key_code !== 8'h00 || rx.key_extended !== 1'b0 ||
        rx.key_release !== 1'b0 || rx.key_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s got=bd%h bv%b fe%b ec%h kc%h ke%b kr%b kv%b want=all0",
               name, rx.byte_data, rx.byte_valid, rx.frame_error,
               rx.err_count, rx.key_code, rx.key_extended,
               rx.key_release, rx.key_valid);
    end
  endtask

  task automatic check_err_count(input string name, input logic [7:0] e);
    total++;
    if (rx.err_count !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, rx.err_count, e);
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_zero("reset_outputs");
    @(posedge Clock); #1 Resetn = 1'b1;
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    check_zero("post_reset_idle");
  endtask

  task automatic test_single();
    expect_byte(8'h1C);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_drained("single");
    @(negedge Clock);
    check_err_count("single_err_count", 8'd0);
    total++;
    if (rx.key_code !== 8'h1C || rx.byte_data !== 8'h1C) begin
      bad++;
      $display("FAIL single_held got=%h/%h want=1c/1c",
               rx.key_code, rx.byte_data);
    end
  endtask

  task automatic test_break();
    expect_byte(8'hF0);
    expect_byte(8'h1C);
    expect_key(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_drained("break");
  endtask

  task automatic test_extended();
    expect_byte(8'hE0);
    expect_byte(8'hF0);
    expect_byte(8'h75);
    expect_key(8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check_drained("ext_break");
    expect_byte(8'h29);
    expect_key(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1);
    check_drained("after_ext");
  endtask

  task automatic test_frame_errors();
    err_pend = 1;
    send_frame(8'h1C, 1'b1, 1'b1);
    check_drained("parity_err");
    @(negedge Clock);
    check_err_count("parity_err_count", 8'd1);
    total++;
    if (rx.byte_data !== last_good) begin
      bad++;
      $display("FAIL parity_byte_hold got=%h want=%h",
               rx.byte_data, last_good);
    end
    err_pend = 1;
    send_frame(8'h1C, 1'b0, 1'b0);
    check_drained("stop_err");
    @(negedge Clock);
    check_err_count("stop_err_count", 8'd2);
  endtask

  task automatic test_timeout();
    int first;
    first = 0;
    err_pend = 1;
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b0);
    @(posedge Clock); #1 ps2_dat = 1'b1;
    repeat (2) @(posedge Clock);
    #1 ps2_clk = 1'b0;
    // Pin to internal fall is 2 sync cycles, then 32 to the pulse.
    for (int n = 1; n <= 45; n++) begin
      @(posedge Clock);
      #1 if (n == 3) ps2_clk = 1'b1;
      @(negedge Clock);
      if (rx.frame_error && first == 0) first = n;
    end
    total++;
    if (first != 34) begin
      bad++;
      $display("FAIL timeout_latency got=%0d want=34", first);
    end
    check_drained("timeout");
    check_err_count("timeout_err_count", 8'd3);
    expect_byte(8'h29);
    expect_key(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1);
    check_drained("after_timeout");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h6B;
    expect_byte(8'hE0);
    send_frame(8'hE0, 1'b0, 1'b1);
    check_drained("pre_reset_e0");
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(d[i]);
    @(posedge Clock); #1 Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    ps2_dat = 1'b1;
    @(negedge Clock);
    check_zero("midframe_reset");
    repeat (4) @(posedge Clock);
    expect_byte(8'h5A);
    expect_key(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_drained("after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_extended();
    test_frame_errors();
    test_timeout();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
